// File: rtl/matmul_seq.sv
// Sequential signed fixed-point matrix multiplier, C = A x B.
// One multiply-accumulate per clock. Each result element takes N MAC cycles followed by
// one WRITE cycle that rescales, range-checks and stores the element.
module matmul_seq #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned BIN_POS     = 8,
  parameter int unsigned MATRIX_SIZE = 3,
  parameter bit          SATURATE    = 1'b1
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0] a,
  input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0] b,
  output logic                                        ready,
  output logic                                        complete,
  output logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0] result,
  output logic                                        overflow
);

  localparam int unsigned N    = MATRIX_SIZE;
  localparam int unsigned MatW = N * N * DATA_WIDTH;
  // Wide enough that a sum of N full-precision products can never overflow.
  localparam int unsigned AccW = 2 * DATA_WIDTH + $clog2(N) + 1;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned OffW = (MatW > 1) ? $clog2(MatW) : 1;
  localparam int unsigned ExtW = AccW - 2 * DATA_WIDTH;

  localparam logic [IdxW-1:0]       IdxLast = IdxW'(N - 1);
  localparam logic [DATA_WIDTH-1:0] MaxPos  = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MinNeg  = {1'b1, {(DATA_WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StMac, StWrite, StDone} state_e;

  state_e                 state_q;
  logic [MatW-1:0]        a_q;
  logic [MatW-1:0]        b_q;
  logic signed [AccW-1:0] acc_q;
  logic [IdxW-1:0]        i_q;
  logic [IdxW-1:0]        j_q;
  logic [IdxW-1:0]        k_q;

  logic [OffW-1:0]               a_off;
  logic [OffW-1:0]               b_off;
  logic [OffW-1:0]               c_off;
  logic signed [DATA_WIDTH-1:0]  a_el;
  logic signed [DATA_WIDTH-1:0]  b_el;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [AccW-1:0]        prod_ext;
  logic signed [AccW-1:0]        shifted;
  logic                          in_range;
  logic [DATA_WIDTH-1:0]         elem;

  // Operand selection, product and the rescale / range-check of the finished accumulator.
  always_comb begin
    a_off    = OffW'((32'(i_q) * N + 32'(k_q)) * DATA_WIDTH);
    b_off    = OffW'((32'(k_q) * N + 32'(j_q)) * DATA_WIDTH);
    c_off    = OffW'((32'(i_q) * N + 32'(j_q)) * DATA_WIDTH);
    a_el     = a_q[a_off +: DATA_WIDTH];
    b_el     = b_q[b_off +: DATA_WIDTH];
    prod     = a_el * b_el;
    prod_ext = {{ExtW{prod[2*DATA_WIDTH-1]}}, prod};
    // Arithmetic shift floors toward minus infinity.
    shifted  = acc_q >>> BIN_POS;
    // In range when every bit above the target sign bit matches it.
    in_range = (&shifted[AccW-1:DATA_WIDTH-1]) | ~(|shifted[AccW-1:DATA_WIDTH-1]);
    elem     = shifted[DATA_WIDTH-1:0];
    if (!in_range && SATURATE) begin
      elem = shifted[AccW-1] ? MinNeg : MaxPos;
    end
  end

  // Control FSM with registered handshake outputs, operand latches, accumulator and result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      ready    <= 1'b1;
      complete <= 1'b0;
      overflow <= 1'b0;
      result   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            acc_q    <= '0;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            overflow <= 1'b0;
            complete <= 1'b0;
            ready    <= 1'b0;
            state_q  <= StMac;
          end
        end
        StMac: begin
          acc_q <= acc_q + prod_ext;
          if (k_q == IdxLast) begin
            state_q <= StWrite;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        StWrite: begin
          result[c_off +: DATA_WIDTH] <= elem;
          if (!in_range) begin
            overflow <= 1'b1;
          end
          acc_q <= '0;
          k_q   <= '0;
          if (j_q == IdxLast) begin
            j_q <= '0;
            if (i_q == IdxLast) begin
              state_q  <= StDone;
              ready    <= 1'b1;
              complete <= 1'b1;
            end else begin
              i_q     <= i_q + 1'b1;
              state_q <= StMac;
            end
          end else begin
            j_q     <= j_q + 1'b1;
            state_q <= StMac;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/matmul_seq.md
# matmul_seq

Sequential fixed-point matrix multiplier computing C = A × B for square MATRIX_SIZE × MATRIX_SIZE operands, using one multiply-accumulate per clock. It is the parametrised successor to the fixed-size determinant blocks. It shares their flattened-matrix operand format, signed Q(DATA_WIDTH−BIN_POS).BIN_POS arithmetic and ready/complete handshake. It adds an explicit start strobe, a selectable saturation mode and an overflow flag, and it feeds the navigation transform chain.

## Interface
- DATA_WIDTH, 16: element width, signed two's complement.
- BIN_POS, 8: fractional bits per element.
- MATRIX_SIZE, 3: N, matrix dimension, ≥ 1.
- SATURATE, 1: 1 = clamp out-of-range results; 0 = wrap (keep low DATA_WIDTH bits).
- clk  in  1  clock, all state on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  begin an operation; accepted only while ready=1.
- a  in  N*N*DATA_WIDTH  matrix A; element (r,c) at bits [(r*N+c)*DATA_WIDTH +: DATA_WIDTH].
- b  in  N*N*DATA_WIDTH  matrix B, same layout.
- ready  out  1  idle or done; able to accept start.
- complete  out  1  result valid; held until the next accepted start or reset.
- result  out  N*N*DATA_WIDTH  matrix C, same layout.
- overflow  out  1  at least one C element was clamped or wrapped in the last operation.

## Operation
- States: IDLE, MAC, WRITE, DONE.
- Reset (rst=0) forces state IDLE, ready=1, complete=0, overflow=0, result=0, and clears the accumulator and indices. Reset mid-operation abandons the work; no partial result is kept.
- IDLE/DONE with start=1:
  - latch a and b into internal copies; inputs may change afterwards;
  - clear the accumulator, set i=j=k=0, clear overflow and complete;
  - go to MAC.
- start while in MAC or WRITE is ignored.
- MAC: acc += a_lat(i,k) * b_lat(k,j), a signed full-precision product.
  - k<N−1: k++.
  - k=N−1: go to WRITE.
- WRITE:
  - s = acc >>> BIN_POS, arithmetic shift, truncation toward −∞.
  - If s is within signed DATA_WIDTH range, result(i,j)=s.
  - Otherwise, with SATURATE=1, result(i,j) = max positive (0x7F..F) or min negative (0x80..0) by sign; with SATURATE=0, result(i,j) = s[DATA_WIDTH−1:0]. Set overflow=1 in both cases.
  - Clear acc and k. Advance j, then i, row-major.
  - Last element goes to DONE; otherwise back to MAC.
- DONE: ready=1, complete=1, result and overflow stable.
- Accumulator width: 2*DATA_WIDTH + clog2(N)+1 bits, so it never overflows internally.
- result elements not yet written keep their previous values during an operation; only complete qualifies result.

## Timing
- Start accepted at edge E0.
- ready=0 and complete=0 from after E0.
- Each element takes N MAC cycles plus 1 WRITE cycle.
- complete=1 and ready=1 from after edge E0 + N*N*(N+1). Examples: N=2 gives 12, N=3 gives 36.
- result(i,j) is updated at the edge ending its WRITE cycle.
- A start in DONE is accepted the same way as in IDLE. complete drops the cycle after acceptance, which allows back-to-back operations with one-cycle turnaround.
- Reset deassertion needs no recovery cycles: start is accepted at the first rising edge with rst=1.

## Test plan
- Identity: N=2, DATA_WIDTH=16, BIN_POS=8, a = identity (0x0100 diagonal, 0 elsewhere), b={0x0180,0xFF00,0x0040,0x0300}. Required: result=b, overflow=0, complete exactly 12 cycles after start.
- Fractional and negative: N=2, a={0x0180,0,0,0x0200}, b={0x0100,0xFF80,0,0x0100}. Required: result={0x0180,0xFF40,0,0x0200}. Also a(0,0)=0xFFFF, b(0,0)=0x0080, rest 0, must give result(0,0)=0xFFFF (floor).
- Saturation, SATURATE=1, N=2:
  - a=b all 0x7F00: all results 0x7FFF, overflow=1.
  - a all 0x7F00, b all 0x8100: all results 0x8000, overflow=1.
  - Same first case with SATURATE=0: all results 0x0200, overflow=1.
- Handshake:
  - Pulse start again mid-MAC: ignored, timing unchanged.
  - Change a and b after acceptance: result unaffected.
  - Issue start in DONE: complete drops next cycle, overflow clears, new result follows 12 cycles later.
- Reset mid-operation: assert rst=0 asynchronously at cycle 5 of an N=3 run. Required: immediately ready=1, complete=0, result=0, overflow=0. A new start after release completes in 36 cycles with a correct result.
- Random regression for N=1..4: seeded random elements in ±10.0 with random fractions, compared against a software Q-format model including the floor and saturation rules.
